// File: rtl/stack_seq_pkg.sv
// ---------------------------------------------------------------------------
// stack_seq_pkg
// Shared types and constants for the stack operation sequencer.
//   - op_e    : operation encoding carried on op_code
//   - state_e : sequencer state register encoding
//   - SEQ_W / SEQ_DEPTH : default data width and stack capacity
//   - operand-count and growth lookups used by the accept-time legality check
// Optional feature macro used by the files that import this package:
//   STKSEQ_FLAGS_EN (zero / carry flags on arithmetic and logic results)
// ---------------------------------------------------------------------------
package stack_seq_pkg;

  localparam int SEQ_W     = 8;
  localparam int SEQ_DEPTH = 32;

  typedef enum logic [2:0] {
    OP_DUP   = 3'd0,
    OP_PUSHI = 3'd1,
    OP_POP   = 3'd2,
    OP_ADD   = 3'd3,
    OP_SUB   = 3'd4,
    OP_AND   = 3'd5,
    OP_OR    = 3'd6,
    OP_NOT   = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RDA  = 3'd1,
    ST_RDB  = 3'd2,
    ST_PUSH = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  // Entries each op must find on the stack, two bits per op, op 7 in the MSBs:
  // NOT=1 OR=2 AND=2 SUB=2 ADD=2 POP=1 PUSHI=0 DUP=1
  localparam logic [15:0] OP_NEED_LUT = {2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0, 2'd1};

  // Ops that leave the stack one entry deeper (DUP and PUSHI)
  localparam logic [7:0] OP_GROW_LUT = 8'b0000_0011;

  function automatic logic [1:0] opNeed(input op_e op);
    return OP_NEED_LUT[{op, 1'b0} +: 2];
  endfunction

  function automatic logic opGrows(input op_e op);
    return OP_GROW_LUT[op];
  endfunction

  function automatic logic opIsBinary(input op_e op);
    return (opNeed(op) == 2'd2);
  endfunction

endpackage

// File: rtl/stack_seq_alu.sv
// ---------------------------------------------------------------------------
// stack_seq_alu
// Purely combinational result generator for the stack sequencer.
//   op_i     : operation being executed
//   a_i      : operand A, the old top of stack
//   b_i      : operand B, the entry below the top (binary ops only)
//   result_o : value to be pushed back (DUP passes A through)
//   carry_o  : only with STKSEQ_FLAGS_EN; ADD carry out or SUB borrow (A > B)
// ---------------------------------------------------------------------------
module stack_seq_alu
  import stack_seq_pkg::*;
#(
  parameter int W = SEQ_W
) (
  input  op_e          op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] result_o
`ifdef STKSEQ_FLAGS_EN
  ,
  output logic         carry_o
`endif
);

  // Subtraction is B - A because A is the more recently pushed operand.
  always_comb begin
    result_o = a_i;
`ifdef STKSEQ_FLAGS_EN
    carry_o = 1'b0;
`endif
    case (op_i)
      OP_ADD: begin
`ifdef STKSEQ_FLAGS_EN
        {carry_o, result_o} = {1'b0, a_i} + {1'b0, b_i};
`else
        result_o = a_i + b_i;
`endif
      end
      OP_SUB: begin
        result_o = b_i - a_i;
`ifdef STKSEQ_FLAGS_EN
        carry_o = (a_i > b_i);
`endif
      end
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_NOT:  result_o = ~a_i;
      default: result_o = a_i;
    endcase
  end

endmodule

// File: rtl/stack_op_sequencer.sv
// ---------------------------------------------------------------------------
// stack_op_sequencer
// Sole driver of a W-bit, DEPTH-entry circular stack. Takes one operation per
// op_valid/op_ready handshake, refuses underflow/overflow up front using its
// own depth counter, then walks the pop/read/compute/push sequence.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   op_valid/op_ready   : operation handshake (ready only in IDLE)
//   op_code, op_imm     : operation and PUSHI immediate
//   stk_push/pop/tos    : stack strobes, decoded from state only
//   stk_din, stk_dout   : stack write data / read data (valid while tos)
//   res_valid, res_data : result pulse and value (pushed value, or popped one)
//   err                 : one-cycle pulse for a refused operation
//   depth               : current number of stack entries
//   flag_z, flag_c      : only with STKSEQ_FLAGS_EN
// ---------------------------------------------------------------------------
module stack_op_sequencer
  import stack_seq_pkg::*;
#(
  parameter int W     = SEQ_W,
  parameter int DEPTH = SEQ_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [2:0]             op_code,
  input  logic [W-1:0]           op_imm,
  output logic                   stk_push,
  output logic                   stk_pop,
  output logic                   stk_tos,
  output logic [W-1:0]           stk_din,
  input  logic [W-1:0]           stk_dout,
  output logic                   res_valid,
  output logic [W-1:0]           res_data,
  output logic                   err,
  output logic [$clog2(DEPTH):0] depth
`ifdef STKSEQ_FLAGS_EN
  ,
  output logic                   flag_z,
  output logic                   flag_c
`endif
);

  localparam int DW = $clog2(DEPTH) + 1;

  state_e         state_q, state_d;
  op_e            op_q, op_d;
  op_e            opIn;
  logic [W-1:0]   opA_q, opA_d;
  logic [W-1:0]   din_q, din_d;
  logic [W-1:0]   res_q, res_d;
  logic [DW-1:0]  depth_q, depth_d;
  logic           accept;
  logic           illegal;
  logic [W-1:0]   aluA;
  logic [W-1:0]   aluResult;
`ifdef STKSEQ_FLAGS_EN
  logic           aluCarry;
  logic           flagZ_q, flagZ_d;
  logic           flagC_q, flagC_d;
`endif

  // In RDA the top of stack is on stk_dout this very cycle, so it feeds the
  // ALU directly; in RDB the latched A and the live B are combined.
  assign aluA = (state_q == ST_RDA) ? stk_dout : opA_q;

  stack_seq_alu #(.W(W)) u_alu (
    .op_i     (op_q),
    .a_i      (aluA),
    .b_i      (stk_dout),
    .result_o (aluResult)
`ifdef STKSEQ_FLAGS_EN
    ,
    .carry_o  (aluCarry)
`endif
  );

  // Strobes and handshakes come straight from registered state.
  assign op_ready  = (state_q == ST_IDLE);
  assign stk_tos   = (state_q == ST_RDA) || (state_q == ST_RDB);
  assign stk_pop   = ((state_q == ST_RDA) && (op_q != OP_DUP)) || (state_q == ST_RDB);
  assign stk_push  = (state_q == ST_PUSH);
  assign res_valid = (state_q == ST_PUSH) || (state_q == ST_DONE);
  assign err       = (state_q == ST_ERR);
  assign stk_din   = din_q;
  assign res_data  = res_q;
  assign depth     = depth_q;
`ifdef STKSEQ_FLAGS_EN
  assign flag_z    = flagZ_q;
  assign flag_c    = flagC_q;
`endif

  assign opIn    = op_e'(op_code);
  assign accept  = op_valid && op_ready;
  assign illegal = (depth_q < DW'(opNeed(opIn))) ||
                   (opGrows(opIn) && (depth_q == DW'(DEPTH)));

  // Next-state logic. Results are captured on the edge that enters PUSH or
  // DONE so stk_din, res_data and the flags are stable for that whole cycle.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opA_d   = opA_q;
    din_d   = din_q;
    res_d   = res_q;
`ifdef STKSEQ_FLAGS_EN
    flagZ_d = flagZ_q;
    flagC_d = flagC_q;
`endif
    depth_d = depth_q + DW'(stk_push) - DW'(stk_pop);

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d = opIn;
          if (illegal) begin
            state_d = ST_ERR;
          end else if (opIn == OP_PUSHI) begin
            state_d = ST_PUSH;
            din_d   = op_imm;
            res_d   = op_imm;
          end else begin
            state_d = ST_RDA;
          end
        end
      end
      ST_RDA: begin
        opA_d = stk_dout;
        if (op_q == OP_POP) begin
          state_d = ST_DONE;
          res_d   = stk_dout;
        end else if (opIsBinary(op_q)) begin
          state_d = ST_RDB;
        end else begin
          state_d = ST_PUSH;
          din_d   = aluResult;
          res_d   = aluResult;
`ifdef STKSEQ_FLAGS_EN
          if (op_q == OP_NOT) begin
            flagZ_d = (aluResult == '0);
            flagC_d = 1'b0;
          end
`endif
        end
      end
      ST_RDB: begin
        state_d = ST_PUSH;
        din_d   = aluResult;
        res_d   = aluResult;
`ifdef STKSEQ_FLAGS_EN
        flagZ_d = (aluResult == '0);
        flagC_d = aluCarry;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Single state/data register bank; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_DUP;
      opA_q   <= '0;
      din_q   <= '0;
      res_q   <= '0;
      depth_q <= '0;
`ifdef STKSEQ_FLAGS_EN
      flagZ_q <= 1'b0;
      flagC_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opA_q   <= opA_d;
      din_q   <= din_d;
      res_q   <= res_d;
      depth_q <= depth_d;
`ifdef STKSEQ_FLAGS_EN
      flagZ_q <= flagZ_d;
      flagC_q <= flagC_d;
`endif
    end
  end

endmodule
